// File: rtl/pic_priority_resolver_if.sv
// Bus bundle for pic_priority_resolver.
// master: drives the request lines, mask, OCW2 command and acknowledge (CPU/bench side).
// slave : the resolver; returns INT, the vector byte and the IRR/ISR views.
interface pic_priority_resolver_if;
  logic [7:0] IR;           // interrupt request lines, synchronous to clk
  logic       LTIM;         // 1 = level-triggered, 0 = edge-triggered
  logic       AEOI;         // automatic end-of-interrupt enable
  logic [4:0] VectorAdress; // upper five bits of the vector
  logic [7:0] IMR;          // 1 masks the line
  logic [2:0] ControlBits;  // OCW2 {R,SL,EOI}
  logic [2:0] IntLevel;     // OCW2 level for specific EOI
  logic       OCW2_stb;     // one-cycle command strobe
  logic       INTA_n;       // active-low acknowledge, synchronous to clk
  logic       INT;          // interrupt request to CPU
  logic [7:0] DataOut;      // vector byte during second acknowledge
  logic       DataOutEn;    // DataOut valid
  logic [7:0] IRR;          // interrupt request register
  logic [7:0] ISR;          // in-service register

  modport master (
    output IR, LTIM, AEOI, VectorAdress, IMR, ControlBits, IntLevel, OCW2_stb, INTA_n,
    input  INT, DataOut, DataOutEn, IRR, ISR
  );

  modport slave (
    input  IR, LTIM, AEOI, VectorAdress, IMR, ControlBits, IntLevel, OCW2_stb, INTA_n,
    output INT, DataOut, DataOutEn, IRR, ISR
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// 8-line 8259-style priority resolver: request capture (edge or level), fixed priority
// with IR0 highest, in-service nesting, two-pulse INTA vector sequence and OCW2 EOI.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - pic_priority_resolver_if.slave (requests, mask, OCW2, INTA_n in;
//           INT, DataOut/DataOutEn, IRR, ISR out)
module pic_priority_resolver (
  input logic                     clk,
  input logic                     rst_n,
  pic_priority_resolver_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAck1, StAck2} state_e;

  state_e     state_q;
  logic [7:0] ir_q, irr_q, isr_q, irr_d, isr_d;
  logic       inta_q;
  logic       int_q, douten_q, spurious_q;
  logic [7:0] dout_q;
  logic [2:0] lvl_q;

  logic [7:0] cand, isr_clr, isr_set;
  logic       win_found, isr_found, win_valid;
  logic [2:0] win_lvl, isr_low;
  logic       inta_fall, inta_rise, ack_take, ack_done;

  assign inta_fall = inta_q & ~bus.INTA_n;
  assign inta_rise = ~inta_q & bus.INTA_n;
  assign ack_take  = (state_q == StIdle) & inta_fall;
  assign ack_done  = (state_q == StAck2) & inta_rise;

  // Fixed priority: the lowest index wins, and must beat the highest-priority in-service level.
  always_comb begin
    cand      = irr_q & ~bus.IMR;
    win_found = 1'b0;
    win_lvl   = 3'd0;
    isr_found = 1'b0;
    isr_low   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_lvl   = 3'(i);
      end
      if (isr_q[i]) begin
        isr_found = 1'b1;
        isr_low   = 3'(i);
      end
    end
    win_valid = win_found & (~isr_found | (win_lvl < isr_low));
  end

  always_comb begin
    if (bus.LTIM) begin
      irr_d = bus.IR;
    end else begin
      // Set on a new rising edge, drop as soon as the line is seen low.
      irr_d = (irr_q | (bus.IR & ~ir_q)) & bus.IR;
      if (ack_take && win_valid) irr_d[win_lvl] = 1'b0;
    end

    isr_clr = 8'h00;
    if (bus.OCW2_stb) begin
      case (bus.ControlBits)
        3'b001:  isr_clr = isr_q & (~isr_q + 8'd1); // isolate lowest set bit
        3'b011:  isr_clr[bus.IntLevel] = 1'b1;
        default: isr_clr = 8'h00;
      endcase
    end
    if (ack_done && bus.AEOI && !spurious_q) isr_clr[lvl_q] = 1'b1;

    isr_set = 8'h00;
    if (ack_take && win_valid) isr_set[win_lvl] = 1'b1;

    // Clear first, then set: a same-bit set survives.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ir_q       <= 8'h00;
      irr_q      <= 8'h00;
      isr_q      <= 8'h00;
      inta_q     <= 1'b1;
      int_q      <= 1'b0;
      douten_q   <= 1'b0;
      dout_q     <= 8'h00;
      lvl_q      <= 3'd0;
      spurious_q <= 1'b0;
    end else begin
      ir_q   <= bus.IR;
      inta_q <= bus.INTA_n;
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      case (state_q)
        StIdle: begin
          int_q    <= win_valid & ~inta_fall;
          douten_q <= 1'b0;
          dout_q   <= 8'h00;
          if (inta_fall) begin
            lvl_q      <= win_valid ? win_lvl : 3'd7;
            spurious_q <= ~win_valid;
            state_q    <= StAck1;
          end
        end
        StAck1: begin
          int_q <= 1'b0;
          if (inta_fall) begin
            state_q  <= StAck2;
            douten_q <= 1'b1;
            dout_q   <= {bus.VectorAdress, lvl_q};
          end
        end
        StAck2: begin
          int_q <= 1'b0;
          if (inta_rise) begin
            state_q  <= StIdle;
            douten_q <= 1'b0;
            dout_q   <= 8'h00;
          end else begin
            douten_q <= 1'b1;
            dout_q   <= {bus.VectorAdress, lvl_q};
          end
        end
        default: begin
          state_q  <= StIdle;
          int_q    <= 1'b0;
          douten_q <= 1'b0;
          dout_q   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.INT       = int_q;
  assign bus.DataOut   = dout_q;
  assign bus.DataOutEn = douten_q;
  assign bus.IRR       = irr_q;
  assign bus.ISR       = isr_q;

endmodule

// File: doc/pic_priority_resolver.md
PIC_PRIORITY_RESOLVER -- requirements
Module: pic_priority_resolver

Interface
REQ-001 The block SHALL have no parameters; it SHALL support exactly 8 interrupt lines, with IR0 as the highest priority.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; it SHALL be sampled on the rising edge of clk.
REQ-004 IR  input  8  interrupt request lines, already synchronised to clk.
REQ-005 LTIM  input  1  trigger mode select: 1 = level-triggered, 0 = edge-triggered.
REQ-006 AEOI  input  1  automatic end-of-interrupt enable.
REQ-007 VectorAdress  input  5  upper five bits of the interrupt vector.
REQ-008 IMR  input  8  interrupt mask register; a 1 masks the corresponding line.
REQ-009 ControlBits  input  3  OCW2 {R,SL,EOI} bits.
REQ-010 IntLevel  input  3  OCW2 level field, used for specific EOI.
REQ-011 OCW2_stb  input  1  one-cycle pulse indicating that ControlBits and IntLevel are valid.
REQ-012 INTA_n  input  1  active-low interrupt acknowledge, already synchronised to clk.
REQ-013 INT  output  1  registered interrupt request to the CPU.
REQ-014 DataOut  output  8  vector byte driven during the second acknowledge.
REQ-015 DataOutEn  output  1  high while DataOut is valid.
REQ-016 IRR  output  8  interrupt request register.
REQ-017 ISR  output  8  in-service register.

Function
REQ-018 Edge mode (LTIM=0): IRR[i] SHALL set on the clock after IR[i] is sampled 1 while registered ir_q[i] is 0; IRR[i] SHALL clear when IR[i] is sampled 0.
REQ-019 Level mode (LTIM=1): IRR[i] SHALL equal IR[i] delayed by one clock.
REQ-020 Candidate set: IRR & ~IMR.
  - Winner: lowest-index bit of the candidate set.
  - The winner is valid only if its index is strictly lower than the lowest set bit of ISR, or if ISR is 0.
REQ-021 INT SHALL be 1 one clock after a valid winner exists, provided the state is IDLE; otherwise INT SHALL be 0.
REQ-022 INTA_n edges SHALL be detected by comparing INTA_n against its registered value inta_q.
REQ-023 The state machine SHALL have three states: IDLE, ACK1 and ACK2.
REQ-024 IDLE -> ACK1 on an INTA_n falling edge. On that transition the block SHALL:
  - latch the current winner into lvl (3 bits), or latch lvl=7 and spurious=1 if no valid winner exists;
  - if not spurious, set ISR[lvl] and clear IRR[lvl] (edge mode only);
  - drive INT to 0.
REQ-025 ACK1 -> ACK2 on the next INTA_n falling edge; DataOut SHALL equal {VectorAdress, lvl} and DataOutEn SHALL be 1 while in ACK2.
REQ-026 ACK2 -> IDLE on an INTA_n rising edge. On that transition:
  - DataOutEn SHALL go to 0;
  - if AEOI=1 and not spurious, ISR[lvl] SHALL be cleared in the same cycle.
REQ-027 DataOut SHALL be 8'h00 whenever DataOutEn is 0.
REQ-028 On OCW2_stb=1, EOI handling SHALL be as follows:
  - ControlBits=3'b001 (non-specific EOI): clear the lowest-index set bit of ISR;
  - ControlBits=3'b011 (specific EOI): clear ISR[IntLevel];
  - all other codes: ignored, no state change.
REQ-029 Non-specific EOI with ISR=0 SHALL cause no change.
REQ-030 When an EOI clear and an ISR set occur in the same cycle, the clear SHALL be applied first and the set second, so a set of the same bit wins.
REQ-031 Changes to IMR while in ACK1 or ACK2 SHALL NOT alter the latched lvl.
REQ-032 A new IR edge arriving during ACK1 or ACK2 SHALL still be captured in IRR.
REQ-033 INT SHALL stay 0 until the state returns to IDLE.
REQ-034 An INTA_n rising edge in ACK1 SHALL cause no state change.
REQ-035 An INTA_n falling edge in ACK2 SHALL be ignored.

Reset
REQ-036 When rst_n=0 at a clock edge, the following SHALL reset as stated:
  - IRR, ISR, DataOut, lvl and spurious to 0;
  - INT and DataOutEn to 0;
  - ir_q to 0;
  - inta_q to 1;
  - state to IDLE.
REQ-037 Reset asserted mid-sequence (in ACK1 or ACK2) SHALL abort the acknowledge cycle with no ISR update beyond the reset value.
REQ-038 For the first clock after reset release, an IR line held at 1 SHALL be treated as a rising edge in edge mode.

Verification
REQ-039 Edge mode, IMR=0, VectorAdress=5'h08: pulse IR[3], then apply two INTA_n pulses -> the bench SHALL see:
  - INT=1 two clocks after the IR edge;
  - ISR=8'h08 and IRR[3]=0 after the first INTA_n;
  - DataOut=8'h43 with DataOutEn=1 during the second INTA_n.
REQ-040 Level mode with IR[5] and IR[2] both held high and IMR=8'h04 -> INT=1 and the served level SHALL be 5; after the second INTA_n, ISR=8'h20.
REQ-041 With ISR=8'h02 (level 1 in service), request IR[4] -> INT SHALL stay 0. After non-specific EOI (ControlBits=3'b001) -> ISR=0 and INT=1 on the following clock.
REQ-042 With AEOI=1, complete a full acknowledge on IR0 -> ISR SHALL return to 8'h00 on the INTA_n rising edge that ends ACK2.
REQ-043 Spurious acknowledge: with IR held low, apply two INTA_n pulses -> DataOut SHALL be {VectorAdress,3'b111} and ISR SHALL remain 0.
REQ-044 Apply specific EOI (ControlBits=3'b011, IntLevel=6) with ISR=8'hC0 -> ISR=8'h80. Asserting rst_n=0 during ACK2 -> state IDLE and DataOutEn=0 on the next clock.
